// File: rtl/aexm_dmif.sv
// Data-memory interface: accepts one load/store per pipeline advance and runs the
// dcache req/ack handshake. Optional bus timeout is enabled by AEXM_DMIF_TIMEOUT_EN.
module aexm_dmif #(
    parameter int AW = 32
`ifdef AEXM_DMIF_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 255
`endif
) (
    input  logic          gclk,
    input  logic          grst,
    input  logic          ld_req,
    input  logic          st_req,
    input  logic [AW-1:0] addr,
    input  logic [1:0]    size,
    input  logic [31:0]   st_data,
    output logic [3:0]    dwbsel,
    output logic [31:0]   ld_data,
    output logic          x_en,
    output logic          dc_en,
    output logic          dc_we,
    output logic [AW-3:0] dc_addr,
    output logic [3:0]    dc_sel,
    output logic [31:0]   dc_wdata,
    input  logic          dc_ack,
    input  logic [31:0]   dc_rdata,
    output logic          mis_err,
    output logic          bus_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          dc_en_q, dc_en_d;
    logic          dc_we_q, dc_we_d;
    logic [AW-3:0] dc_addr_q, dc_addr_d;
    logic [31:0]   dc_wdata_q, dc_wdata_d;
    logic [3:0]    dwbsel_q, dwbsel_d;
    logic [31:0]   ld_data_q, ld_data_d;
    logic          mis_err_q, mis_err_d;
    logic          bus_err_q, bus_err_d;

`ifdef AEXM_DMIF_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] cnt_q, cnt_d;
`endif

    logic [3:0] byte_sel;
    logic [3:0] lane_sel;
    logic       misaligned;
    logic       req_any;

    // Big-endian byte lanes: byte offset 0 is the most significant lane.
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
        assign byte_sel[gi] = (addr[1:0] == 2'(3 - gi));
    end

    always_comb begin
        lane_sel   = 4'hF;
        misaligned = 1'b0;
        case (size)
            2'd0: lane_sel = byte_sel;
            2'd1: begin
                lane_sel   = addr[1] ? 4'h3 : 4'hC;
                misaligned = addr[0];
            end
            2'd2: begin
                lane_sel   = 4'hF;
                misaligned = (addr[1:0] != 2'b00);
            end
            default: misaligned = 1'b1;
        endcase
    end

    assign req_any = ld_req | st_req;

    always_comb begin
        state_d    = state_q;
        dc_en_d    = dc_en_q;
        dc_we_d    = dc_we_q;
        dc_addr_d  = dc_addr_q;
        dc_wdata_d = dc_wdata_q;
        dwbsel_d   = dwbsel_q;
        ld_data_d  = ld_data_q;
        mis_err_d  = 1'b0;
        bus_err_d  = 1'b0;
`ifdef AEXM_DMIF_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            S_BUSY: begin
                if (dc_ack) begin
                    state_d = S_DONE;
                    dc_en_d = 1'b0;
                    if (!dc_we_q) begin
                        ld_data_d = dc_rdata;
                    end
                end
`ifdef AEXM_DMIF_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    state_d   = S_DONE;
                    dc_en_d   = 1'b0;
                    ld_data_d = 32'hFFFF_FFFF;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            default: begin
                // IDLE and DONE both accept, which allows back-to-back accesses.
                state_d = S_IDLE;
                if (req_any) begin
                    if (misaligned) begin
                        mis_err_d = 1'b1;
                    end else begin
                        state_d    = S_BUSY;
                        dc_en_d    = 1'b1;
                        dc_we_d    = st_req;
                        dc_addr_d  = addr[AW-1:2];
                        dc_wdata_d = st_data;
                        dwbsel_d   = lane_sel;
`ifdef AEXM_DMIF_TIMEOUT_EN
                        cnt_d      = 8'd0;
`endif
                    end
                end
            end
        endcase
    end

    always_ff @(posedge gclk) begin
        if (grst) begin
            state_q    <= S_IDLE;
            dc_en_q    <= 1'b0;
            dc_we_q    <= 1'b0;
            dc_addr_q  <= '0;
            dc_wdata_q <= 32'h0;
            dwbsel_q   <= 4'hF;
            ld_data_q  <= 32'h0;
            mis_err_q  <= 1'b0;
            bus_err_q  <= 1'b0;
`ifdef AEXM_DMIF_TIMEOUT_EN
            cnt_q      <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            dc_en_q    <= dc_en_d;
            dc_we_q    <= dc_we_d;
            dc_addr_q  <= dc_addr_d;
            dc_wdata_q <= dc_wdata_d;
            dwbsel_q   <= dwbsel_d;
            ld_data_q  <= ld_data_d;
            mis_err_q  <= mis_err_d;
            bus_err_q  <= bus_err_d;
`ifdef AEXM_DMIF_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign x_en     = (state_q != S_BUSY);
    assign dc_en    = dc_en_q;
    assign dc_we    = dc_we_q;
    assign dc_addr  = dc_addr_q;
    assign dc_sel   = dwbsel_q;
    assign dc_wdata = dc_wdata_q;
    assign dwbsel   = dwbsel_q;
    assign ld_data  = ld_data_q;
    assign mis_err  = mis_err_q;
    assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_aexm_dmif.sv
// Scoreboard bench for aexm_dmif: stimulus pushes expected requests/completions,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_aexm_dmif;

    logic        gclk = 1'b0;
    logic        grst = 1'b1;
    logic        ld_req = 1'b0;
    logic        st_req = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [1:0]  size = 2'd0;
    logic [31:0] st_data = 32'h0;
    logic [3:0]  dwbsel;
    logic [31:0] ld_data;
    logic        x_en;
    logic        dc_en;
    logic        dc_we;
    logic [29:0] dc_addr;
    logic [3:0]  dc_sel;
    logic [31:0] dc_wdata;
    logic        dc_ack = 1'b0;
    logic [31:0] dc_rdata = 32'h0;
    logic        mis_err;
    logic        bus_err;

    always #5 gclk = ~gclk;

    aexm_dmif #(
        .AW(32)
`ifdef AEXM_DMIF_TIMEOUT_EN
        , .TIMEOUT(4)
`endif
    ) dut (
        .gclk(gclk), .grst(grst), .ld_req(ld_req), .st_req(st_req),
        .addr(addr), .size(size), .st_data(st_data), .dwbsel(dwbsel),
        .ld_data(ld_data), .x_en(x_en), .dc_en(dc_en), .dc_we(dc_we),
        .dc_addr(dc_addr), .dc_sel(dc_sel), .dc_wdata(dc_wdata),
        .dc_ack(dc_ack), .dc_rdata(dc_rdata), .mis_err(mis_err), .bus_err(bus_err)
    );

    typedef struct {
        logic [29:0] waddr;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic [31:0] ldv;
        logic [3:0]  sel;
        logic        berr;
        int          stall;
    } cpl_t;

    req_t       req_q[$];
    cpl_t       cpl_q[$];
    logic [3:0] mis_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int mis_cnt = 0;
    int bus_cnt = 0;
    bit mon_en = 1'b0;
    bit abort_flag = 1'b0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Monitor / scoreboard
    initial begin
        int   stall_cnt;
        logic dc_en_prev;
        logic x_en_prev;
        req_t r;
        cpl_t c;
        logic [3:0] ms;
        stall_cnt  = 0;
        dc_en_prev = 1'b0;
        x_en_prev  = 1'b1;
        wait (mon_en);
        forever begin
            @(negedge gclk);
            if (dc_en && !dc_en_prev) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_request", 32'(dc_en), 32'd0);
                end else begin
                    r = req_q.pop_front();
                    chk("dc_addr", 32'(dc_addr), 32'(r.waddr));
                    chk("dc_sel", 32'(dc_sel), 32'(r.sel));
                    chk("dc_we", 32'(dc_we), 32'(r.we));
                    chk("dc_wdata", dc_wdata, r.wdata);
                end
            end
            if (!x_en) stall_cnt++;
            if (x_en && !x_en_prev) begin
                if (abort_flag) begin
                    abort_flag = 1'b0;
                end else if (cpl_q.size() == 0) begin
                    chk("unexpected_completion", 32'(x_en), 32'd0);
                end else begin
                    c = cpl_q.pop_front();
                    chk("ld_data", ld_data, c.ldv);
                    chk("dwbsel", 32'(dwbsel), 32'(c.sel));
                    chk("bus_err", 32'(bus_err), 32'(c.berr));
                    chk("stall_cycles", 32'(stall_cnt), 32'(c.stall));
                end
                stall_cnt = 0;
            end
            if (mis_err) begin
                mis_cnt++;
                if (mis_q.size() == 0) begin
                    chk("unexpected_mis_err", 32'(mis_err), 32'd0);
                end else begin
                    ms = mis_q.pop_front();
                    chk("mis_dwbsel", 32'(dwbsel), 32'(ms));
                    chk("mis_x_en", 32'(x_en), 32'd1);
                    chk("mis_dc_en", 32'(dc_en), 32'd0);
                end
            end
            if (bus_err) bus_cnt++;
            if (grst) stall_cnt = 0;
            dc_en_prev = dc_en;
            x_en_prev  = x_en;
        end
    end

    task automatic access(input logic ld, input logic st, input logic [31:0] a,
                          input logic [1:0] sz, input logic [31:0] d, input int waits,
                          input logic [31:0] rd, input logic [3:0] exp_sel,
                          input logic [31:0] exp_ld);
        req_t r;
        cpl_t c;
        r.waddr = a[31:2]; r.sel = exp_sel; r.we = st; r.wdata = d;
        c.ldv = exp_ld; c.sel = exp_sel; c.berr = 1'b0; c.stall = waits + 1;
        req_q.push_back(r);
        cpl_q.push_back(c);
        ld_req = ld; st_req = st; addr = a; size = sz; st_data = d;
        @(posedge gclk); #1;
        ld_req = 1'b0; st_req = 1'b0;
        chk("accept_stall", 32'(x_en), 32'd0);
        repeat (waits) begin
            @(posedge gclk); #1;
        end
        dc_ack = 1'b1; dc_rdata = rd;
        @(posedge gclk); #1;
        dc_ack = 1'b0;
        $display("txn %s addr=%h size=%0d waits=%0d ld_data=%h dwbsel=%h",
                 st ? "store" : "load", a, sz, waits, ld_data, dwbsel);
    endtask

    task automatic misaligned(input logic [31:0] a, input logic [1:0] sz,
                              input logic [3:0] exp_sel);
        mis_q.push_back(exp_sel);
        ld_req = 1'b1; addr = a; size = sz;
        @(posedge gclk); #1;
        ld_req = 1'b0;
        chk("mis_no_stall", 32'(x_en), 32'd1);
        @(posedge gclk); #1;
        chk("mis_pulse_end", 32'(mis_err), 32'd0);
        $display("txn misaligned addr=%h size=%0d dwbsel=%h", a, sz, dwbsel);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge gclk);
        #1 grst = 1'b0;
        mon_en = 1'b1;

        // Idle with random ack, which must be ignored
        for (int i = 0; i < 10; i++) begin
            dc_ack = 1'($urandom_range(0, 1));
            @(negedge gclk);
            chk("idle_dwbsel", 32'(dwbsel), 32'hF);
            chk("idle_x_en", 32'(x_en), 32'd1);
            chk("idle_dc_en", 32'(dc_en), 32'd0);
            chk("idle_ld_data", ld_data, 32'h0);
        end
        @(posedge gclk); #1;
        dc_ack = 1'b0;
        @(posedge gclk); #1;
        $display("txn idle dwbsel=%h ld_data=%h", dwbsel, ld_data);

        access(1'b1, 1'b0, 32'h0000_1003, 2'd0, 32'h0, 2, 32'hAABB_CCDD, 4'h1, 32'hAABB_CCDD);
        @(posedge gclk); #1;

        // Back-to-back: second access accepted in the DONE cycle
        access(1'b0, 1'b1, 32'h0000_2002, 2'd1, 32'h1234_1234, 0, 32'h0, 4'h3, 32'hAABB_CCDD);
        access(1'b1, 1'b0, 32'h0000_2000, 2'd2, 32'h0, 1, 32'hCAFE_F00D, 4'hF, 32'hCAFE_F00D);
        @(posedge gclk); #1;

        access(1'b1, 1'b0, 32'h0000_0000, 2'd0, 32'h0, 0, 32'h1122_3344, 4'h8, 32'h1122_3344);
        access(1'b0, 1'b1, 32'h0000_0001, 2'd0, 32'h7777_7777, 1, 32'hDEAD_DEAD, 4'h4, 32'h1122_3344);
        access(1'b1, 1'b0, 32'h0000_0002, 2'd0, 32'h0, 0, 32'h0102_0304, 4'h2, 32'h0102_0304);
        access(1'b1, 1'b0, 32'h0000_0004, 2'd1, 32'h0, 3, 32'hBEEF_0000, 4'hC, 32'hBEEF_0000);
        access(1'b1, 1'b1, 32'h0000_0010, 2'd2, 32'h55AA_55AA, 0, 32'h0BAD_0BAD, 4'hF, 32'hBEEF_0000);
        @(posedge gclk); #1;

        misaligned(32'h0000_0006, 2'd2, 4'hF);
        misaligned(32'h0000_0005, 2'd1, 4'hF);
        misaligned(32'h0000_0000, 2'd3, 4'hF);

        // Reset in the 2nd BUSY cycle, ack arrives the cycle after
        begin
            req_t r;
            r.waddr = 30'h0C00; r.sel = 4'hF; r.we = 1'b0; r.wdata = 32'h0;
            req_q.push_back(r);
        end
        ld_req = 1'b1; addr = 32'h0000_3000; size = 2'd2; st_data = 32'h0;
        @(posedge gclk); #1;
        ld_req = 1'b0;
        @(posedge gclk); #1;
        chk("rst_busy2_x_en", 32'(x_en), 32'd0);
        abort_flag = 1'b1;
        grst = 1'b1;
        @(posedge gclk); #1;
        grst = 1'b0;
        chk("rst_x_en", 32'(x_en), 32'd1);
        chk("rst_dc_en", 32'(dc_en), 32'd0);
        chk("rst_ld_data", ld_data, 32'h0);
        dc_ack = 1'b1; dc_rdata = 32'h9999_9999;
        @(posedge gclk); #1;
        dc_ack = 1'b0;
        chk("rst_ack_ignored_x_en", 32'(x_en), 32'd1);
        chk("rst_ack_ignored_ld", ld_data, 32'h0);
        chk("rst_ack_ignored_dc_en", 32'(dc_en), 32'd0);
        @(posedge gclk); #1;
        chk("rst_ack_ignored_ld2", ld_data, 32'h0);
        $display("txn reset-in-busy x_en=%b dc_en=%b ld_data=%h", x_en, dc_en, ld_data);

`ifdef AEXM_DMIF_TIMEOUT_EN
        begin
            req_t r;
            cpl_t c;
            int   waited;
            r.waddr = 30'h1000; r.sel = 4'hF; r.we = 1'b0; r.wdata = 32'h0;
            c.ldv = 32'hFFFF_FFFF; c.sel = 4'hF; c.berr = 1'b1; c.stall = 4;
            req_q.push_back(r);
            cpl_q.push_back(c);
            ld_req = 1'b1; addr = 32'h0000_4000; size = 2'd2;
            @(posedge gclk); #1;
            ld_req = 1'b0;
            waited = 0;
            while (!x_en && waited < 20) begin
                @(posedge gclk); #1;
                waited++;
            end
            chk("timeout_release", 32'(x_en), 32'd1);
            chk("timeout_dc_en", 32'(dc_en), 32'd0);
            @(posedge gclk); #1;
            $display("txn timeout ld_data=%h x_en=%b", ld_data, x_en);
        end
`endif

        repeat (3) @(posedge gclk);
        #1;
        chk("req_q_empty", 32'(req_q.size()), 32'd0);
        chk("cpl_q_empty", 32'(cpl_q.size()), 32'd0);
        chk("mis_q_empty", 32'(mis_q.size()), 32'd0);
        chk("mis_err_cycles", 32'(mis_cnt), 32'd3);
`ifdef AEXM_DMIF_TIMEOUT_EN
        chk("bus_err_cycles", 32'(bus_cnt), 32'd1);
`else
        chk("bus_err_cycles", 32'(bus_cnt), 32'd0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
